// File: rtl/barrel_arbiter_pkg.sv
// rtl/barrel_arbiter_pkg.sv - shared widths, shifter opcodes and FSM encodings for barrel_arbiter
package barrel_arbiter_pkg;

    localparam int REG_WIDTH   = 32;
    localparam int OPSEL_WIDTH = 3;
    localparam int SA_WIDTH    = 5;

    localparam logic [OPSEL_WIDTH-1:0] OP_SLL = 3'b000;
    localparam logic [OPSEL_WIDTH-1:0] OP_ROL = 3'b001;
    localparam logic [OPSEL_WIDTH-1:0] OP_SRL = 3'b010;
    localparam logic [OPSEL_WIDTH-1:0] OP_ROR = 3'b011;
    localparam logic [OPSEL_WIDTH-1:0] OP_SRA = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic opsel_illegal(input logic [OPSEL_WIDTH-1:0] opsel);
        return !(opsel == OP_SLL || opsel == OP_ROL || opsel == OP_SRL ||
                 opsel == OP_ROR || opsel == OP_SRA);
    endfunction

endpackage

// File: rtl/barrel_arbiter_barrel.sv
// rtl/barrel_arbiter_barrel.sv - combinational barrel shifter (sll/rol/srl/ror/sra); illegal opcodes yield 0
module barrel
    import barrel_arbiter_pkg::*;
(
    input  logic [OPSEL_WIDTH-1:0] opsel,
    input  logic [SA_WIDTH-1:0]    amount,
    input  logic [REG_WIDTH-1:0]   data,
    output logic [REG_WIDTH-1:0]   result
);

    // Rotates come from shifting a doubled copy so wrap-around needs no second shifter.
    logic [2*REG_WIDTH-1:0] dbl_left;
    logic [2*REG_WIDTH-1:0] dbl_right;

    assign dbl_left  = {data, data} << amount;
    assign dbl_right = {data, data} >> amount;

    always_comb begin
        result = '0;
        case (opsel)
            OP_SLL:  result = data << amount;
            OP_ROL:  result = dbl_left[2*REG_WIDTH-1:REG_WIDTH];
            OP_SRL:  result = data >> amount;
            OP_ROR:  result = dbl_right[REG_WIDTH-1:0];
            OP_SRA:  result = $unsigned($signed(data) >>> amount);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/barrel_arbiter.sv
// rtl/barrel_arbiter.sv - round-robin sharing of one barrel shifter between two requesters
// Optional BARREL_ARB_OPCHK_EN: flags illegal opcodes on rsp_err (otherwise rsp_err is tied 0).
module barrel_arbiter
    import barrel_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [OPSEL_WIDTH-1:0] req0_opsel,
    input  logic [SA_WIDTH-1:0]    req0_amount,
    input  logic [REG_WIDTH-1:0]   req0_data,
    input  logic [OPSEL_WIDTH-1:0] req1_opsel,
    input  logic [SA_WIDTH-1:0]    req1_amount,
    input  logic [REG_WIDTH-1:0]   req1_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [REG_WIDTH-1:0]   rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_grant;
    logic                   grant;
    logic                   handshake;
    logic [OPSEL_WIDTH-1:0] hold_opsel;
    logic [SA_WIDTH-1:0]    hold_amount;
    logic [REG_WIDTH-1:0]   hold_data;
    logic                   hold_id;
    logic [REG_WIDTH-1:0]   shift_result;

    barrel u_barrel (
        .opsel  (hold_opsel),
        .amount (hold_amount),
        .data   (hold_data),
        .result (shift_result)
    );

    // Contention alternates away from the last winner; a lone requester always wins.
    always_comb begin
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last_grant;
        endcase
    end

    assign handshake = |req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake)             state_nxt = EXEC;
            EXEC:                               state_nxt = RESP;
            RESP:    if (rsp_valid & rsp_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state == IDLE && |req_valid)
            req_ready = grant ? 2'b10 : 2'b01;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            hold_opsel  <= '0;
            hold_amount <= '0;
            hold_data   <= '0;
            hold_id     <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= 1'b0;
        end else begin
            if (handshake) begin
                hold_opsel  <= grant ? req1_opsel  : req0_opsel;
                hold_amount <= grant ? req1_amount : req0_amount;
                hold_data   <= grant ? req1_data   : req0_data;
                hold_id     <= grant;
                last_grant  <= grant;
            end
            if (state == EXEC) begin
                rsp_data <= shift_result;
                rsp_id   <= hold_id;
            end
        end
    end

`ifdef BARREL_ARB_OPCHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)             rsp_err <= 1'b0;
        else if (state == EXEC) rsp_err <= opsel_illegal(hold_opsel);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
